// File: rtl/gb_audio_pkg.sv
// Shared Game Boy audio definitions: mixer FSM states, datapath widths and the
// DC offset that recentres 0..15 DAC levels around zero.
package gb_audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_SCALE,
    ST_OUT
  } mix_state_e;

  localparam int LVL_W     = 4;
  localparam int SLVL_W    = 5;
  localparam int ACC_W     = 7;
  localparam int MIX_W     = 10;
  localparam int SMP_W     = 16;
  localparam int VOL_W     = 3;
  localparam int DC_OFFSET = 15;

  // 2*level - 15 wraps correctly in 5 bits because the true result always fits.
  function automatic logic signed [SLVL_W-1:0] signed_level(input logic [LVL_W-1:0] lvl,
                                                            input logic              on);
    logic [SLVL_W-1:0] centred;
    centred = {lvl, 1'b0} - SLVL_W'(DC_OFFSET);
    return on ? signed'(centred) : '0;
  endfunction

endpackage

// File: rtl/sound_mixer_if.sv
// Sample request/return channel between the mixer and the AC97 frame generator.
interface sound_mixer_if;
  import gb_audio_pkg::*;

  logic                    sample_req;
  logic                    sample_ack;
  logic signed [SMP_W-1:0] left_sample;
  logic signed [SMP_W-1:0] right_sample;
  logic                    sample_valid;
  logic                    overrun;

  modport master (
    input  sample_req, sample_ack,
    output left_sample, right_sample, sample_valid, overrun
  );

  modport slave (
    output sample_req, sample_ack,
    input  left_sample, right_sample, sample_valid, overrun
  );

endinterface

// File: rtl/mixer_scale.sv
// Applies NR50 volume (vol+1) to one accumulated side and gates it with the
// master enable.
module mixer_scale
  import gb_audio_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [VOL_W-1:0] vol_i,
  input  logic                    master_en_i,
  output logic signed [MIX_W-1:0] mix_o
);

  logic signed [MIX_W-1:0] acc_ext;
  logic signed [MIX_W-1:0] gain;

  assign acc_ext = MIX_W'(acc_i);
  assign gain    = signed'(MIX_W'({1'b0, vol_i}) + MIX_W'(1));
  assign mix_o   = master_en_i ? acc_ext * gain : '0;

endmodule

// File: rtl/sound_mixer.sv
// Four-channel Game Boy stereo mixer: one time-shared accumulator pass per
// AC97 sample request, with a one-deep request queue and valid/ack output.
module sound_mixer
  import gb_audio_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int OUT_SHIFT = 6
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [LVL_W-1:0] ch1_level,
  input  logic [LVL_W-1:0] ch2_level,
  input  logic [LVL_W-1:0] ch3_level,
  input  logic [LVL_W-1:0] ch4_level,
  input  logic             ch1_on_flag,
  input  logic             ch2_on_flag,
  input  logic             ch3_on_flag,
  input  logic             ch4_on_flag,
  input  logic             SO1_ch1_enable,
  input  logic             SO1_ch2_enable,
  input  logic             SO1_ch3_enable,
  input  logic             SO1_ch4_enable,
  input  logic             SO2_ch1_enable,
  input  logic             SO2_ch2_enable,
  input  logic             SO2_ch3_enable,
  input  logic             SO2_ch4_enable,
  input  logic [VOL_W-1:0] SO1_output_level,
  input  logic [VOL_W-1:0] SO2_output_level,
  input  logic             sound_master_enable,
  sound_mixer_if.master    smp_bus
);

  localparam int IDX_W = $clog2(NUM_CH);

  mix_state_e                        state_q;
  logic        [IDX_W-1:0]           idx_q;
  logic        [NUM_CH-1:0][LVL_W-1:0] lvl_in, lvl_q;
  logic        [NUM_CH-1:0]          on_in, on_q;
  logic        [NUM_CH-1:0]          so1_in, so1_q;
  logic        [NUM_CH-1:0]          so2_in, so2_q;
  logic        [VOL_W-1:0]           vol1_q, vol2_q;
  logic                              master_q;
  logic                              pending_q;
  logic signed [ACC_W-1:0]           acc_l_q, acc_r_q, acc_l_d, acc_r_d;
  logic signed [SLVL_W-1:0]          ch_s;
  logic signed [ACC_W-1:0]           ch_s_ext;
  logic signed [MIX_W-1:0]           mix_l, mix_r, mix_l_q, mix_r_q;
  logic signed [SMP_W-1:0]           left_q, right_q;
  logic                              valid_q;
  logic                              overrun_q;

  assign lvl_in = {ch4_level, ch3_level, ch2_level, ch1_level};
  assign on_in  = {ch4_on_flag, ch3_on_flag, ch2_on_flag, ch1_on_flag};
  assign so1_in = {SO1_ch4_enable, SO1_ch3_enable, SO1_ch2_enable, SO1_ch1_enable};
  assign so2_in = {SO2_ch4_enable, SO2_ch3_enable, SO2_ch2_enable, SO2_ch1_enable};

  // SO1 feeds the right accumulator, SO2 the left one.
  always_comb begin
    ch_s     = signed_level(lvl_q[idx_q], on_q[idx_q]);
    ch_s_ext = ACC_W'(ch_s);
    acc_r_d  = so1_q[idx_q] ? acc_r_q + ch_s_ext : acc_r_q;
    acc_l_d  = so2_q[idx_q] ? acc_l_q + ch_s_ext : acc_l_q;
  end

  mixer_scale u_scale_left (
    .acc_i      (acc_l_q),
    .vol_i      (vol2_q),
    .master_en_i(master_q),
    .mix_o      (mix_l)
  );

  mixer_scale u_scale_right (
    .acc_i      (acc_r_q),
    .vol_i      (vol1_q),
    .master_en_i(master_q),
    .mix_o      (mix_r)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      lvl_q     <= '0;
      on_q      <= '0;
      so1_q     <= '0;
      so2_q     <= '0;
      vol1_q    <= '0;
      vol2_q    <= '0;
      master_q  <= 1'b0;
      pending_q <= 1'b0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (smp_bus.sample_ack) valid_q <= 1'b0;
      if (smp_bus.sample_req && pending_q) overrun_q <= 1'b1;
      if (smp_bus.sample_req && !pending_q && state_q != ST_IDLE) pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (smp_bus.sample_req || pending_q) begin
            lvl_q     <= lvl_in;
            on_q      <= on_in;
            so1_q     <= so1_in;
            so2_q     <= so2_in;
            vol1_q    <= SO1_output_level;
            vol2_q    <= SO2_output_level;
            master_q  <= sound_master_enable;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc_l_q <= acc_l_d;
          acc_r_q <= acc_r_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_CH - 1)) state_q <= ST_SCALE;
        end
        ST_SCALE: begin
          mix_l_q <= mix_l;
          mix_r_q <= mix_r;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // An unacknowledged sample being replaced is a lost result.
          left_q  <= SMP_W'(mix_l_q) <<< OUT_SHIFT;
          right_q <= SMP_W'(mix_r_q) <<< OUT_SHIFT;
          valid_q <= 1'b1;
          if (valid_q && !smp_bus.sample_ack) overrun_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign smp_bus.left_sample  = left_q;
  assign smp_bus.right_sample = right_q;
  assign smp_bus.sample_valid = valid_q;
  assign smp_bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Directed and randomized checks of sound_mixer against an arithmetic mixing
// model; inputs are driven and outputs sampled on the falling clock edge.
module tb_sound_mixer;

  logic       clk     = 1'b0;
  logic       reset_b = 1'b0;
  logic [3:0] ch_level [4];
  logic       ch_on    [4];
  logic       so1_en   [4];
  logic       so2_en   [4];
  logic [2:0] vol1   = '0;
  logic [2:0] vol2   = '0;
  logic       master = 1'b0;

  int errors = 0;
  int checks = 0;
  int expL;
  int expR;
  int lat;
  int seen;

  sound_mixer_if bus ();

  sound_mixer #(.NUM_CH(4), .OUT_SHIFT(6)) dut (
    .clk                (clk),
    .reset_b            (reset_b),
    .ch1_level          (ch_level[0]),
    .ch2_level          (ch_level[1]),
    .ch3_level          (ch_level[2]),
    .ch4_level          (ch_level[3]),
    .ch1_on_flag        (ch_on[0]),
    .ch2_on_flag        (ch_on[1]),
    .ch3_on_flag        (ch_on[2]),
    .ch4_on_flag        (ch_on[3]),
    .SO1_ch1_enable     (so1_en[0]),
    .SO1_ch2_enable     (so1_en[1]),
    .SO1_ch3_enable     (so1_en[2]),
    .SO1_ch4_enable     (so1_en[3]),
    .SO2_ch1_enable     (so2_en[0]),
    .SO2_ch2_enable     (so2_en[1]),
    .SO2_ch3_enable     (so2_en[2]),
    .SO2_ch4_enable     (so2_en[3]),
    .SO1_output_level   (vol1),
    .SO2_output_level   (vol2),
    .sound_master_enable(master),
    .smp_bus            (bus)
  );

  always #5 clk = ~clk;

  // Sum of recentred levels on one side, times volume, gated, times 64.
  function automatic int mixModel(input bit rightSide);
    int sum = 0;
    int vol;
    bit en;
    for (int i = 0; i < 4; i++) begin
      en = rightSide ? so1_en[i] : so2_en[i];
      if (en && ch_on[i]) sum += 2 * int'(ch_level[i]) - 15;
    end
    vol = rightSide ? int'(vol1) : int'(vol2);
    if (!master) return 0;
    return sum * (vol + 1) * 64;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic setChannels(input int lvl, input bit on, input bit s1, input bit s2);
    for (int i = 0; i < 4; i++) begin
      ch_level[i] = 4'(lvl);
      ch_on[i]    = on;
      so1_en[i]   = s1;
      so2_en[i]   = s2;
    end
  endtask

  task automatic randomizeInputs();
    for (int i = 0; i < 4; i++) begin
      ch_level[i] = 4'($urandom_range(0, 15));
      ch_on[i]    = 1'($urandom_range(0, 1));
      so1_en[i]   = 1'($urandom_range(0, 1));
      so2_en[i]   = 1'($urandom_range(0, 1));
    end
    vol1   = 3'($urandom_range(0, 7));
    vol2   = 3'($urandom_range(0, 7));
    master = ($urandom_range(0, 3) != 0);
  endtask

  // Latch the model's answer for the current inputs and pulse sample_req once.
  task automatic applyStimulus();
    expR = mixModel(1'b1);
    expL = mixModel(1'b0);
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    while (bus.sample_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic checkSample(input string tag);
    checkOutput({tag, "_left"}, bus.left_sample, expL);
    checkOutput({tag, "_right"}, bus.right_sample, expR);
  endtask

  task automatic ackSample(input string tag);
    bus.sample_ack = 1'b1;
    @(negedge clk);
    bus.sample_ack = 1'b0;
    checkOutput({tag, "_ack_clears_valid"}, bus.sample_valid, 0);
  endtask

  task automatic countValid(input int cycles, output int hits);
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.sample_valid !== 1'b0) hits++;
    end
  endtask

  initial begin
    setChannels(0, 1'b0, 1'b0, 1'b0);
    bus.sample_req = 1'b0;
    bus.sample_ack = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_left", bus.left_sample, 0);
    checkOutput("reset_right", bus.right_sample, 0);
    checkOutput("reset_valid", bus.sample_valid, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    reset_b = 1'b1;
    @(negedge clk);

    $display("[TB] full-scale sample");
    setChannels(15, 1'b1, 1'b1, 1'b1);
    vol1 = 3'd7; vol2 = 3'd7; master = 1'b1;
    applyStimulus();
    randomizeInputs();
    waitValid(lat);
    checkOutput("full_latency", lat, 6);
    checkOutput("full_left", bus.left_sample, 30720);
    checkOutput("full_right", bus.right_sample, 30720);
    ackSample("full");
    checkOutput("full_hold_after_ack", bus.left_sample, 30720);

    $display("[TB] ch1 level 0 right only");
    setChannels(7, 1'b0, 1'b1, 1'b1);
    ch_level[0] = 4'd0; ch_on[0] = 1'b1; so1_en[0] = 1'b1; so2_en[0] = 1'b0;
    vol1 = 3'd0; vol2 = 3'($urandom_range(0, 7)); master = 1'b1;
    applyStimulus();
    randomizeInputs();
    waitValid(lat);
    checkOutput("ch1_latency", lat, 6);
    checkOutput("ch1_right", bus.right_sample, -960);
    checkOutput("ch1_left", bus.left_sample, 0);
    ackSample("ch1");

    $display("[TB] master disabled");
    randomizeInputs();
    master = 1'b0;
    applyStimulus();
    randomizeInputs();
    waitValid(lat);
    checkOutput("moff_valid", bus.sample_valid, 1);
    checkOutput("moff_left", bus.left_sample, 0);
    checkOutput("moff_right", bus.right_sample, 0);
    ackSample("moff");

    $display("[TB] randomized samples");
    for (int n = 0; n < 6; n++) begin
      randomizeInputs();
      applyStimulus();
      randomizeInputs();
      waitValid(lat);
      checkOutput("rand_latency", lat, 6);
      checkSample("rand");
      checkOutput("rand_overrun", bus.overrun, 0);
      ackSample("rand");
    end

    $display("[TB] unacknowledged sample overwritten");
    setChannels(15, 1'b1, 1'b1, 1'b1);
    vol1 = 3'd7; vol2 = 3'd7; master = 1'b1;
    applyStimulus();
    waitValid(lat);
    checkOutput("hold1_latency", lat, 6);
    setChannels(0, 1'b1, 1'b1, 1'b1);
    vol1 = 3'd3; vol2 = 3'd1;
    applyStimulus();
    repeat (5) @(negedge clk);
    checkOutput("hold_old_data_stable", bus.left_sample, 30720);
    checkOutput("hold_no_overrun_yet", bus.overrun, 0);
    @(negedge clk);
    checkOutput("hold_new_right", bus.right_sample, -15360);
    checkOutput("hold_new_left", bus.left_sample, -7680);
    checkOutput("hold_valid", bus.sample_valid, 1);
    checkOutput("hold_overrun", bus.overrun, 1);
    ackSample("hold");
    checkOutput("hold_overrun_sticky", bus.overrun, 1);

    reset_b = 1'b0;
    @(negedge clk);
    checkOutput("rst2_overrun", bus.overrun, 0);
    reset_b = 1'b1;
    @(negedge clk);

    $display("[TB] three back-to-back requests");
    randomizeInputs();
    master = 1'b1;
    expR = mixModel(1'b1);
    expL = mixModel(1'b0);
    bus.sample_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("triple_pending_no_overrun", bus.overrun, 0);
    @(negedge clk);
    bus.sample_req = 1'b0;
    checkOutput("triple_overrun", bus.overrun, 1);
    waitValid(lat);
    checkOutput("triple_first_latency", lat, 4);
    checkSample("triple_first");
    ackSample("triple_first");
    waitValid(lat);
    checkOutput("triple_second_gap", lat, 6);
    checkSample("triple_second");
    ackSample("triple_second");
    countValid(20, seen);
    checkOutput("triple_no_third_out", seen, 0);

    $display("[TB] reset during accumulation");
    setChannels(15, 1'b1, 1'b1, 1'b1);
    vol1 = 3'd7; vol2 = 3'd7; master = 1'b1;
    applyStimulus();
    waitValid(lat);
    checkOutput("prerst_latency", lat, 6);
    applyStimulus();
    repeat (2) @(negedge clk);
    reset_b = 1'b0;
    #1;
    checkOutput("midrst_left", bus.left_sample, 0);
    checkOutput("midrst_right", bus.right_sample, 0);
    checkOutput("midrst_valid", bus.sample_valid, 0);
    checkOutput("midrst_overrun", bus.overrun, 0);
    @(negedge clk);
    reset_b = 1'b1;
    countValid(20, seen);
    checkOutput("midrst_no_out", seen, 0);
    checkOutput("midrst_overrun_after", bus.overrun, 0);

    randomizeInputs();
    master = 1'b1;
    applyStimulus();
    waitValid(lat);
    checkOutput("post_latency", lat, 6);
    checkSample("post");
    ackSample("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
